// File: rtl/slon5_generated_pkg.sv
// rtl/slon5_generated_pkg.sv - lookup tables shared by the display blocks.
// KTable holds segment patterns with a tag byte above; STable is the alternate set.
package slon5_generated_pkg;

    localparam int TABLE_DEPTH = 16;
    localparam int TABLE_W     = 16;

    localparam logic [TABLE_W-1:0] KTable [TABLE_DEPTH] = '{
        16'hA03F, 16'hA106, 16'hA25B, 16'hA34F, 16'hA466, 16'hA56D, 16'hA67D, 16'hA707,
        16'hA87F, 16'hA96F, 16'hAA77, 16'hAB7C, 16'hAC39, 16'hAD5E, 16'hAE79, 16'hAF71
    };

    localparam logic [TABLE_W-1:0] STable [TABLE_DEPTH] = '{
        16'h5001, 16'h5102, 16'h5204, 16'h5308, 16'h5410, 16'h5520, 16'h5640, 16'h5780,
        16'h58C0, 16'h5960, 16'h5A30, 16'h5B18, 16'h5C0C, 16'h5D06, 16'h5E03, 16'h5F81
    };

endpackage

// File: rtl/table_scan_display_if.sv
// rtl/table_scan_display_if.sv - index write port of the display scanner.
// The controller side is the master; the scanner is the slave.
interface table_scan_display_if #(
    parameter int CH_NUM = 4,
    parameter int IDX_W  = 4,
    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [IDX_W-1:0] wr_idx;

    modport master (output wr_valid, output wr_ch, output wr_idx, input wr_ready);
    modport slave  (input wr_valid, input wr_ch, input wr_idx, output wr_ready);
endinterface

// File: rtl/table_scan_display.sv
// rtl/table_scan_display.sv - time-multiplexed multi-digit table lookup scanner.
// Optional TABLE_SWEEP_EN adds sweep_en_i: all indices advance once per frame.
module table_scan_display
    import slon5_generated_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int DOUT_W       = 8,
    parameter int IDX_W        = 4,
    parameter int TICK_DIV     = 50_000,
    parameter int BLANK_CYCLES = 16,
    parameter int TABLE_ID     = 0,
    parameter int DNUM_POL     = 1,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    table_scan_display_if.slave wr,
`ifdef TABLE_SWEEP_EN
    input  logic                sweep_en_i,
`endif
    output logic [DOUT_W-1:0]   dout_o,
    output logic [CH_NUM-1:0]   dnum_o,
    output logic [CH_W-1:0]     ch_o,
    output logic                frame_tick_o
);

    localparam int PC_W     = $clog2(TICK_DIV);
    localparam int TIDX_W   = $clog2(TABLE_DEPTH);
    localparam logic [PC_W-1:0]   PC_LAST    = PC_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0]   BLANK_LAST = PC_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CH_NUM - 1);
    localparam logic [CH_NUM-1:0] DNUM_IDLE  = (DNUM_POL != 0) ? '0 : '1;

    typedef enum logic {S_BLANK, S_SHOW} state_e;
    localparam state_e RESET_STATE = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    logic [CH_NUM-1:0]   dnum_q, dnum_d;
    logic                ft_q, ft_d;
    logic [IDX_W-1:0]    idx_q [CH_NUM];
    logic [IDX_W-1:0]    idx_d [CH_NUM];
    logic                step_end;
    logic                wr_fire;
    logic [CH_NUM-1:0]   onehot;

    // Indices beyond the table depth, or an unknown TABLE_ID, read as zero.
    function automatic logic [DOUT_W-1:0] table_word(input logic [IDX_W-1:0] idx);
        logic [TABLE_W-1:0] entry;
        logic [TIDX_W-1:0]  tidx;
        entry = '0;
        tidx  = TIDX_W'(idx);
        if (int'(idx) < TABLE_DEPTH) begin
            if (TABLE_ID == 0)      entry = KTable[tidx];
            else if (TABLE_ID == 1) entry = STable[tidx];
        end
        return DOUT_W'(entry);
    endfunction

    // Never let the digit currently being shown change under the viewer.
    assign wr.wr_ready = !rst && !(state_q == S_SHOW && wr.wr_ch == ch_q);

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        dnum_d   = dnum_q;
        ch_d     = ch_q;
        idx_d    = idx_q;
        step_end = (pc_q == PC_LAST);
        wr_fire  = wr.wr_valid && wr.wr_ready;
        onehot   = CH_NUM'(1) << ch_q;
        pc_d     = step_end ? '0 : pc_q + PC_W'(1);
        ft_d     = step_end && (ch_q == CH_LAST);
        if (step_end) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
        end

        case (state_q)
            S_BLANK: begin
                dout_d = '0;
                dnum_d = DNUM_IDLE;
                if (pc_q == BLANK_LAST) state_d = S_SHOW;
            end
            S_SHOW: begin
                dout_d = table_word(idx_q[ch_q]);
                dnum_d = (DNUM_POL != 0) ? onehot : ~onehot;
                if (step_end && BLANK_CYCLES != 0) state_d = S_BLANK;
            end
        endcase

`ifdef TABLE_SWEEP_EN
        if (sweep_en_i && ft_d) begin
            for (int i = 0; i < CH_NUM; i++) idx_d[i] = idx_q[i] + IDX_W'(1);
        end
`endif
        // Applied after the sweep so a coincident write takes precedence.
        if (wr_fire && int'(wr.wr_ch) < CH_NUM) begin
            idx_d[wr.wr_ch] = wr.wr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            pc_q    <= '0;
            ch_q    <= '0;
            dout_q  <= '0;
            dnum_q  <= DNUM_IDLE;
            ft_q    <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) idx_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ch_q    <= ch_d;
            dout_q  <= dout_d;
            dnum_q  <= dnum_d;
            ft_q    <= ft_d;
            for (int i = 0; i < CH_NUM; i++) idx_q[i] <= idx_d[i];
        end
    end

    assign dout_o       = dout_q;
    assign dnum_o       = dnum_q;
    assign ch_o         = ch_q;
    assign frame_tick_o = ft_q;

endmodule

// File: tb/tb_table_scan_display.sv
// tb/tb_table_scan_display.sv - bench for table_scan_display, both digit polarities side by side.
// Expected outputs come from a cycle-count model of the scan schedule.
module tb_table_scan_display;
    import slon5_generated_pkg::*;

    localparam int TD = 8;
    localparam int NC = 4;
    localparam int BL = 2;
`ifdef TABLE_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid;
    logic [1:0] wr_ch;
    logic [3:0] wr_idx;
    logic       sweep_en;
    logic [7:0] dout_a, dout_b;
    logic [3:0] dnum_a, dnum_b;
    logic [1:0] ch_a, ch_b;
    logic       ft_a, ft_b;

    always #5 clk = ~clk;

    table_scan_display_if #(.CH_NUM(NC), .IDX_W(4)) if_a ();
    table_scan_display_if #(.CH_NUM(NC), .IDX_W(4)) if_b ();

    assign if_a.wr_valid = wr_valid;
    assign if_a.wr_ch    = wr_ch;
    assign if_a.wr_idx   = wr_idx;
    assign if_b.wr_valid = wr_valid;
    assign if_b.wr_ch    = wr_ch;
    assign if_b.wr_idx   = wr_idx;

    table_scan_display #(.CH_NUM(NC), .DOUT_W(8), .IDX_W(4), .TICK_DIV(TD), .BLANK_CYCLES(BL),
                         .TABLE_ID(0), .DNUM_POL(1)) dut_a (
        .clk(clk), .rst(rst), .wr(if_a),
`ifdef TABLE_SWEEP_EN
        .sweep_en_i(sweep_en),
`endif
        .dout_o(dout_a), .dnum_o(dnum_a), .ch_o(ch_a), .frame_tick_o(ft_a)
    );

    table_scan_display #(.CH_NUM(NC), .DOUT_W(8), .IDX_W(4), .TICK_DIV(TD), .BLANK_CYCLES(BL),
                         .TABLE_ID(0), .DNUM_POL(0)) dut_b (
        .clk(clk), .rst(rst), .wr(if_b),
`ifdef TABLE_SWEEP_EN
        .sweep_en_i(sweep_en),
`endif
        .dout_o(dout_b), .dnum_o(dnum_b), .ch_o(ch_b), .frame_tick_o(ft_b)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         t, gc, last_ft;
    logic [3:0] idx_m [NC];
    logic [7:0] exp_dout;
    logic [3:0] exp_dnum;
    logic       exp_ft;
    bit         acc;

    function automatic logic [7:0] lo8(input logic [15:0] e);
        return e[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the DUTs against the model, then advance the model.
    task automatic tick();
        int         pc, c;
        bit         show;
        logic       exp_ready;
        logic [3:0] inv;
        #1;
        pc        = t % TD;
        c         = (t / TD) % NC;
        show      = (pc >= BL);
        exp_ready = !rst && !(show && int'(wr_ch) == c);
        inv       = ~exp_dnum;
        check("wr_ready_a", if_a.wr_ready, exp_ready);
        check("wr_ready_b", if_b.wr_ready, exp_ready);
        check("dout_a", dout_a, exp_dout);
        check("dout_b", dout_b, exp_dout);
        check("dnum_a", dnum_a, exp_dnum);
        check("dnum_b", dnum_b, inv);
        check("frame_tick", ft_a, exp_ft);
        check("ch", ch_a, c);
        if (ft_a === 1'b1) begin
            if (last_ft >= 0) check("frame_period", gc - last_ft, NC * TD);
            last_ft = gc;
        end
        acc = 1'b0;
        if (rst) begin
            t = 0;
            for (int k = 0; k < NC; k++) idx_m[k] = '0;
            exp_dout = '0;
            exp_dnum = '0;
            exp_ft   = 1'b0;
            last_ft  = -1;
        end else begin
            exp_dout = show ? lo8(KTable[idx_m[c]]) : 8'h00;
            exp_dnum = show ? 4'(1 << c) : 4'h0;
            exp_ft   = (pc == TD - 1) && (c == NC - 1);
            if (exp_ft && sweep_en && SWEEP) begin
                for (int k = 0; k < NC; k++) idx_m[k] = idx_m[k] + 4'd1;
            end
            if (wr_valid && exp_ready) begin
                acc = 1'b1;
                idx_m[wr_ch] = wr_idx;
            end
            t++;
        end
        gc++;
        @(negedge clk);
    endtask

    task automatic advance_to(input int c, input int pc);
        int n;
        n = 0;
        while ((((t / TD) % NC) != c || (t % TD) != pc) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("advance_timeout", n, 0);
    endtask

    initial begin
        bit done;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_idx   = '0;
        sweep_en = 1'b0;
        rst      = 1'b1;
        t        = 0;
        gc       = 0;
        last_ft  = -1;
        exp_dout = '0;
        exp_dnum = '0;
        exp_ft   = 1'b0;
        for (int k = 0; k < NC; k++) idx_m[k] = '0;
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Free-running scan with no writes.
        repeat (70) tick();

        // Write ch2 while ch0 is shown.
        advance_to(0, 3);
        wr_valid = 1'b1; wr_ch = 2'd2; wr_idx = 4'd5;
        tick();
        check("wr_ch2_accepted", acc, 1);
        wr_valid = 1'b0;
        advance_to(2, 3);
        check("ch2_shows_idx5", dout_a, lo8(KTable[5]));

        // Held write to the displayed channel waits for the next step.
        advance_to(1, 2);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_idx = 4'd7;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            int pcs, cs;
            pcs = t % TD;
            cs  = (t / TD) % NC;
            tick();
            if (acc) begin
                done = 1'b1;
                check("held_accept_step", cs * TD + pcs, 2 * TD);
            end
        end
        if (!done) check("held_write_timeout", done, 1);
        wr_valid = 1'b0;
        advance_to(1, 3);
        check("ch1_shows_idx7", dout_a, lo8(KTable[7]));

        // Randomized writes.
        repeat (300) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_ch    = 2'($urandom_range(0, 3));
            wr_idx   = 4'($urandom);
            tick();
        end
        wr_valid = 1'b0;

        // Reset in the middle of the ch1 step.
        advance_to(1, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_dnum", dnum_a, 0);
        check("rst_dout", dout_a, 0);
        repeat (40) tick();
        advance_to(2, 3);
        check("post_rst_idx0", dout_a, lo8(KTable[0]));

        if (SWEEP) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            sweep_en = 1'b1;
            repeat (3 * NC * TD) tick();
            advance_to(1, 3);
            check("sweep_3_frames", dout_a, lo8(KTable[3]));
            advance_to(3, 7);
            wr_valid = 1'b1; wr_ch = 2'd0; wr_idx = 4'd9;
            tick();
            check("sweep_write_accepted", acc, 1);
            wr_valid = 1'b0;
            sweep_en = 1'b0;
            advance_to(0, 3);
            check("sweep_write_wins", dout_a, lo8(KTable[9]));
            advance_to(1, 3);
            check("sweep_others_inc", dout_a, lo8(KTable[4]));
        end

        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
